// File: rtl/ex_ctrl_pkg.sv
// ex_ctrl_pkg: shared definitions for the EX-stage controller.
//   - opcode field position inside the instruction word
//   - ALU function codes (opcode[3:0] when opcode[5] == 0)
//   - branch opcodes and the opcode[5:2] pattern that selects NPC as operand a
//   - FSM state encoding
package ex_ctrl_pkg;

  localparam int unsigned OpcMsb = 31;
  localparam int unsigned OpcLsb = 26;

  typedef enum logic [3:0] {
    FuncAdd = 4'd0,
    FuncSub = 4'd1,
    FuncMul = 4'd2,
    FuncSgt = 4'd3,
    FuncOr  = 4'd4,
    FuncAnd = 4'd5
  } alu_func_e;

  localparam logic [5:0] OpcBeqz = 6'b110100;
  localparam logic [5:0] OpcBnez = 6'b110101;

  // opcode[5:2] value for which operand a is the next PC instead of A.
  localparam logic [3:0] OpcNpcSel = 4'b1101;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StMul  = 1'b1
  } ex_state_e;

  function automatic logic [5:0] get_opcode(input logic [31:0] ir);
    return ir[OpcMsb:OpcLsb];
  endfunction

  // BEQZ and BNEZ differ only in opcode[0].
  function automatic logic is_branch(input logic [5:0] opc);
    return opc[5:1] == OpcBnez[5:1];
  endfunction

endpackage

// File: rtl/ex_mul_iter.sv
// ex_mul_iter: iterative shift-add multiplier producing the low XLEN bits of a*b.
// Retires MUL_BITS_PER_CYC multiplier bits per cycle over XLEN/MUL_BITS_PER_CYC
// iterations; MUL_BITS_PER_CYC must divide XLEN.
// Ports:
//   clk, rst    clock and synchronous active-high reset (aborts and clears state)
//   start_i     load operands and begin a new multiplication
//   a_i, b_i    operands, sampled when start_i is high
//   done_o      high during the final iteration; product_o is valid in that cycle
//   product_o   low XLEN bits of a_i * b_i
module ex_mul_iter #(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned MUL_BITS_PER_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            done_o,
  output logic [XLEN-1:0] product_o
);

  localparam int unsigned NumIter = XLEN / MUL_BITS_PER_CYC;
  localparam int unsigned CntW    = $clog2(NumIter + 1);
  localparam logic [CntW-1:0] CntLoad = CntW'(NumIter);
  localparam logic [CntW-1:0] CntOne  = CntW'(1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] partial;

  // Sum of the partial products for the low MUL_BITS_PER_CYC multiplier bits.
  always_comb begin
    partial = '0;
    for (int unsigned k = 0; k < MUL_BITS_PER_CYC; k++) begin
      if (mplier_q[k]) begin
        partial = partial + (mcand_q << k);
      end
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    if (start_i) begin
      cnt_d    = CntLoad;
      mcand_d  = a_i;
      mplier_d = b_i;
      acc_d    = '0;
    end else if (cnt_q != '0) begin
      cnt_d    = cnt_q - CntOne;
      mcand_d  = mcand_q << MUL_BITS_PER_CYC;
      mplier_d = mplier_q >> MUL_BITS_PER_CYC;
      acc_d    = acc_q + partial;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
    end
  end

  // Final iteration's contribution is folded in combinationally so the caller
  // can register the full product on the same edge that retires it.
  assign done_o    = (cnt_q == CntOne);
  assign product_o = acc_q + partial;

endmodule

// File: rtl/ex_stage_ctrl.sv
// ex_stage_ctrl: EX-stage sequencing controller between decode and MEM.
// Accepts one ID/EX bundle per id_valid/id_ready handshake, evaluates ALU, address
// and branch ops in one cycle, runs MUL iteratively (stalling decode), and registers
// the result bundle into EX/MEM with a valid/ready hold toward MEM.
// Configuration macro EX_SINGLE_CYCLE_MUL_EN: when defined, MUL is an ordinary
// single-cycle ALU op, ex_mul_iter is not instantiated and busy is tied low.
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   id_valid / id_ready            ID bundle handshake
//   IR_id, NPC_id, A, B, Imm       ID bundle (opcode = IR_id[31:26])
//   mem_ready                      MEM consumes the EX/MEM bundle this cycle
//   ex_valid                       EX/MEM bundle valid
//   IR_ex, NPC_ex, ALU_res, B_ex   registered EX/MEM bundle
//   branch_taken                   one-cycle pulse with a newly registered taken branch
//   busy                           iterative multiply in progress
module ex_stage_ctrl
  import ex_ctrl_pkg::*;
#(
  parameter int unsigned XLEN             = 32,
  parameter int unsigned MUL_BITS_PER_CYC = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  output logic            id_ready,
  input  logic [XLEN-1:0] IR_id,
  input  logic [XLEN-1:0] NPC_id,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [XLEN-1:0] Imm,
  input  logic            mem_ready,
  output logic            ex_valid,
  output logic [XLEN-1:0] IR_ex,
  output logic [XLEN-1:0] NPC_ex,
  output logic [XLEN-1:0] ALU_res,
  output logic [XLEN-1:0] B_ex,
  output logic            branch_taken,
  output logic            busy
);

`ifdef EX_SINGLE_CYCLE_MUL_EN
  localparam bit IterMul = 1'b0;
`else
  localparam bit IterMul = 1'b1;
`endif

  // Decode and operand select
  logic [5:0]      opc;
  logic [3:0]      func;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] add_res;
  logic [XLEN-1:0] alu_res;
  logic            br_taken;
  logic            is_mul;
  logic            accept;

  assign opc      = get_opcode(IR_id[31:0]);
  assign func     = opc[3:0];
  assign op_a     = (opc[5:2] == OpcNpcSel) ? NPC_id : A;
  assign op_b     = opc[4] ? Imm : B;
  assign add_res  = op_a + op_b;
  // Condition uses A itself, not the NPC-selected operand a.
  assign br_taken = is_branch(opc) & (opc[0] ^ (A == '0));
  assign is_mul   = IterMul && !opc[5] && (func == FuncMul);

  always_comb begin
    alu_res = '0;
    if (opc[5]) begin
      alu_res = add_res;
    end else begin
      case (func)
        FuncAdd: alu_res = add_res;
        FuncSub: alu_res = op_a - op_b;
`ifdef EX_SINGLE_CYCLE_MUL_EN
        FuncMul: alu_res = op_a * op_b;
`endif
        FuncSgt: alu_res = {{(XLEN-1){1'b0}}, (op_a > op_b)};
        FuncOr:  alu_res = op_a | op_b;
        FuncAnd: alu_res = op_a & op_b;
        default: alu_res = '0;
      endcase
    end
  end

  // Multiplier
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_product;

`ifdef EX_SINGLE_CYCLE_MUL_EN
  assign mul_done    = 1'b0;
  assign mul_product = '0;
`else
  ex_mul_iter #(
    .XLEN            (XLEN),
    .MUL_BITS_PER_CYC(MUL_BITS_PER_CYC)
  ) u_mul (
    .clk      (clk),
    .rst      (rst),
    .start_i  (mul_start),
    .a_i      (op_a),
    .b_i      (op_b),
    .done_o   (mul_done),
    .product_o(mul_product)
  );
`endif

  // FSM
  ex_state_e state_q, state_d;
  logic      load_alu;
  logic      load_mul;
  logic      ex_valid_q, ex_valid_d;

  assign id_ready = !rst && (state_q == StIdle) && (!ex_valid_q || mem_ready);
  assign accept   = id_valid && id_ready;

  always_comb begin
    state_d   = state_q;
    mul_start = 1'b0;
    load_alu  = 1'b0;
    load_mul  = 1'b0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mul) begin
            mul_start = 1'b1;
            state_d   = StMul;
          end else begin
            load_alu  = 1'b1;
          end
        end
      end
      StMul: begin
        if (mul_done) begin
          load_mul = 1'b1;
          state_d  = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // EX/MEM bundle
  logic [XLEN-1:0] ir_ex_q, ir_ex_d;
  logic [XLEN-1:0] npc_ex_q, npc_ex_d;
  logic [XLEN-1:0] alu_res_q, alu_res_d;
  logic [XLEN-1:0] b_ex_q, b_ex_d;
  logic            br_q, br_d;

  always_comb begin
    ex_valid_d = ex_valid_q;
    ir_ex_d    = ir_ex_q;
    npc_ex_d   = npc_ex_q;
    alu_res_d  = alu_res_q;
    b_ex_d     = b_ex_q;
    br_d       = 1'b0;  // pulse only on the cycle a bundle is first registered

    if (load_alu || load_mul) begin
      ex_valid_d = 1'b1;
    end else if (mem_ready) begin
      ex_valid_d = 1'b0;
    end

    // A MUL accept only happens once the previous bundle has been consumed, so
    // its IR/NPC/B can be captured immediately while ex_valid is low.
    if (load_alu || mul_start) begin
      ir_ex_d  = IR_id;
      b_ex_d   = B;
      npc_ex_d = br_taken ? alu_res : NPC_id;
    end
    if (load_alu) begin
      alu_res_d = alu_res;
      br_d      = br_taken;
    end
    if (load_mul) begin
      alu_res_d = mul_product;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      ex_valid_q <= 1'b0;
      ir_ex_q    <= '0;
      npc_ex_q   <= '0;
      alu_res_q  <= '0;
      b_ex_q     <= '0;
      br_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      ex_valid_q <= ex_valid_d;
      ir_ex_q    <= ir_ex_d;
      npc_ex_q   <= npc_ex_d;
      alu_res_q  <= alu_res_d;
      b_ex_q     <= b_ex_d;
      br_q       <= br_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign IR_ex        = ir_ex_q;
  assign NPC_ex       = npc_ex_q;
  assign ALU_res      = alu_res_q;
  assign B_ex         = b_ex_q;
  assign branch_taken = br_q;
  assign busy         = (state_q == StMul);

endmodule

// File: tb/tb_ex_stage_ctrl.sv
// Directed testbench for ex_stage_ctrl (default build: iterative MUL, 16 iterations).
module tb_ex_stage_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] IR_id;
  logic [31:0] NPC_id;
  logic [31:0] A;
  logic [31:0] B;
  logic [31:0] Imm;
  logic        mem_ready;
  logic        ex_valid;
  logic [31:0] IR_ex;
  logic [31:0] NPC_ex;
  logic [31:0] ALU_res;
  logic [31:0] B_ex;
  logic        branch_taken;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ex_stage_ctrl #(
    .XLEN            (32),
    .MUL_BITS_PER_CYC(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .IR_id       (IR_id),
    .NPC_id      (NPC_id),
    .A           (A),
    .B           (B),
    .Imm         (Imm),
    .mem_ready   (mem_ready),
    .ex_valid    (ex_valid),
    .IR_ex       (IR_ex),
    .NPC_ex      (NPC_ex),
    .ALU_res     (ALU_res),
    .B_ex        (B_ex),
    .branch_taken(branch_taken),
    .busy        (busy)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk_ir(input logic [5:0] opc);
    return {opc, 26'h0012345};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] npc);
    IR_id    = mk_ir(opc);
    A        = a;
    B        = b;
    Imm      = imm;
    NPC_id   = npc;
    id_valid = 1'b1;
  endtask

  task automatic issue(input logic [5:0] opc, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] imm, input logic [31:0] npc);
    drive(opc, a, b, imm, npc);
    tick();
    id_valid = 1'b0;
  endtask

  task automatic run_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp);
    int busy_cycles;
    int bad;
    busy_cycles = 0;
    bad         = 0;
    issue(6'b000010, a, b, 32'h0, 32'h200);
    while (busy && busy_cycles < 100) begin
      busy_cycles++;
      if (id_ready || ex_valid) bad++;
      tick();
    end
    check_eq({tag, "_busy_cycles"}, busy_cycles, 16);
    check_eq({tag, "_ready_or_valid_while_busy"}, bad, 0);
    check_eq({tag, "_ex_valid"}, ex_valid, 1'b1);
    check_eq({tag, "_res"}, ALU_res, exp);
    check_eq({tag, "_npc"}, NPC_ex, 32'h200);
    tick();
    check_eq({tag, "_drain"}, ex_valid, 1'b0);
  endtask

  // Single-cycle ALU table: opcode, A, B, expected (Imm fixed at 100).
  logic [5:0]  t_opc [9] = '{6'b000001, 6'b000100, 6'b000101, 6'b001001, 6'b000011,
                             6'b000011, 6'b010000, 6'b100011, 6'b000000};
  logic [31:0] t_a   [9] = '{32'd5, 32'hF0, 32'hFF, 32'd5, 32'd3,
                             32'hFFFFFFFF, 32'd5, 32'h1000, 32'hFFFFFFFF};
  logic [31:0] t_b   [9] = '{32'd7, 32'h0F, 32'h3C, 32'd3, 32'hFFFFFFFF,
                             32'd3, 32'd7, 32'h8, 32'd2};
  logic [31:0] t_exp [9] = '{32'hFFFFFFFE, 32'hFF, 32'h3C, 32'h0, 32'h0,
                             32'h1, 32'd105, 32'h1008, 32'h1};

  initial begin
    int stray;
    rst       = 1'b1;
    id_valid  = 1'b0;
    mem_ready = 1'b1;
    IR_id     = '0;
    NPC_id    = '0;
    A         = '0;
    B         = '0;
    Imm       = '0;

    // Reset
    tick();
    check_eq("rst_id_ready", id_ready, 1'b0);
    check_eq("rst_ex_valid", ex_valid, 1'b0);
    check_eq("rst_alu_res", ALU_res, 32'h0);
    check_eq("rst_npc_ex", NPC_ex, 32'h0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_branch", branch_taken, 1'b0);
    rst = 1'b0;
    #1;
    check_eq("idle_id_ready", id_ready, 1'b1);

    // ADD RR 5+7
    issue(6'b000000, 32'd5, 32'd7, 32'h0, 32'h44);
    check_eq("add_ex_valid", ex_valid, 1'b1);
    check_eq("add_res", ALU_res, 32'd12);
    check_eq("add_npc", NPC_ex, 32'h44);
    check_eq("add_b_ex", B_ex, 32'd7);
    check_eq("add_ir_ex", IR_ex, mk_ir(6'b000000));
    check_eq("add_branch", branch_taken, 1'b0);
    tick();
    check_eq("add_drain", ex_valid, 1'b0);

    // Iterative MUL
    run_mul("mul_6x7", 32'd6, 32'd7, 32'd42);
    run_mul("mul_ovf", 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);

    // BEQZ taken / BNEZ not taken
    issue(6'b110100, 32'h0, 32'h55, 32'h20, 32'h100);
    check_eq("beqz_ex_valid", ex_valid, 1'b1);
    check_eq("beqz_npc", NPC_ex, 32'h120);
    check_eq("beqz_pulse", branch_taken, 1'b1);
    tick();
    check_eq("beqz_pulse_end", branch_taken, 1'b0);
    check_eq("beqz_drain", ex_valid, 1'b0);
    issue(6'b110101, 32'h0, 32'h55, 32'h20, 32'h100);
    check_eq("bnez_npc", NPC_ex, 32'h100);
    check_eq("bnez_res", ALU_res, 32'h120);
    check_eq("bnez_no_pulse", branch_taken, 1'b0);
    tick();

    // Hold under mem_ready=0, then replacement on the release cycle
    mem_ready = 1'b0;
    drive(6'b110100, 32'h0, 32'h0, 32'h10, 32'h300);
    tick();
    drive(6'b000000, 32'd1, 32'd2, 32'h0, 32'h0);
    check_eq("hold_pulse", branch_taken, 1'b1);
    check_eq("hold_id_ready0", id_ready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("hold_ex_valid", ex_valid, 1'b1);
      check_eq("hold_npc", NPC_ex, 32'h310);
      check_eq("hold_res", ALU_res, 32'h310);
      check_eq("hold_ir", IR_ex, mk_ir(6'b110100));
      check_eq("hold_no_repulse", branch_taken, 1'b0);
      check_eq("hold_id_ready", id_ready, 1'b0);
    end
    mem_ready = 1'b1;
    #1;
    check_eq("release_id_ready", id_ready, 1'b1);
    tick();
    id_valid = 1'b0;
    check_eq("replace_ex_valid", ex_valid, 1'b1);
    check_eq("replace_res", ALU_res, 32'd3);
    check_eq("replace_ir", IR_ex, mk_ir(6'b000000));
    check_eq("replace_branch", branch_taken, 1'b0);

    // Back-to-back at full rate
    for (int i = 1; i <= 3; i++) begin
      drive(6'b000000, 32'(10 * i), 32'(i), 32'h0, 32'h0);
      tick();
      check_eq("b2b_ex_valid", ex_valid, 1'b1);
      check_eq("b2b_res", ALU_res, 32'(11 * i));
    end
    id_valid = 1'b0;
    tick();
    check_eq("b2b_drain", ex_valid, 1'b0);

    // ALU function table
    for (int i = 0; i < 9; i++) begin
      issue(t_opc[i], t_a[i], t_b[i], 32'd100, 32'h0);
      check_eq($sformatf("alu_tbl_%0d", i), ALU_res, t_exp[i]);
    end

    // Reset during MUL iteration 5
    issue(6'b000010, 32'd6, 32'd7, 32'h0, 32'h400);
    repeat (4) tick();
    check_eq("midmul_busy", busy, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("midrst_ex_valid", ex_valid, 1'b0);
    check_eq("midrst_busy", busy, 1'b0);
    check_eq("midrst_res", ALU_res, 32'h0);
    check_eq("midrst_ir", IR_ex, 32'h0);
    stray = 0;
    for (int i = 0; i < 20; i++) begin
      if (ex_valid || busy) stray++;
      tick();
    end
    check_eq("midrst_no_result", stray, 0);
    issue(6'b000000, 32'd1, 32'd1, 32'h0, 32'h0);
    check_eq("post_rst_add", ALU_res, 32'd2);
    check_eq("post_rst_valid", ex_valid, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
